// File: rtl/spmv_cfg_pkg.sv
// Shared register map, bit positions and control-field type for the SpMV loader config block.
// Optional interrupt support is enabled with `define SPMV_CFG_IRQ_EN.
package spmv_cfg_pkg;

  localparam logic [31:0] OFF_CTRL    = 32'h00;
  localparam logic [31:0] OFF_STATUS  = 32'h04;
  localparam logic [31:0] OFF_BASE_LO = 32'h08;
  localparam logic [31:0] OFF_BASE_HI = 32'h0C;
  localparam logic [31:0] OFF_NOW_LO  = 32'h10;
  localparam logic [31:0] OFF_NOW_HI  = 32'h14;
  localparam logic [31:0] OFF_LEN     = 32'h18;
  localparam logic [31:0] OFF_REMAIN  = 32'h1C;

  localparam int unsigned CTRL_LOADER_BIT = 0;
  localparam int unsigned CTRL_RW_BIT     = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;
  localparam int unsigned CTRL_START_BIT  = 31;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  localparam logic [31:0] DEAD_VALUE = 32'hDEADADDE;

  // Field order matches CTRL bits 2:0 so the struct reads back directly.
  typedef struct packed {
    logic irq_en;
    logic rw_mode;
    logic loader_mode;
  } ch_ctrl_t;

endpackage

// File: rtl/spmv_cfg_channel.sv
// One loader channel: CTRL/STATUS/BASE/NOW/LEN/REMAIN registers plus the address stepper.
// CTRL bit2 (irq_en) is stored only when SPMV_CFG_IRQ_EN is defined.
module spmv_cfg_channel
  import spmv_cfg_pkg::*;
#(
  parameter int unsigned HBM_AW     = 64,
  parameter int unsigned STEP_BYTES = 64,
  parameter int unsigned OFF_W      = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [OFF_W-1:0]  offset,
  input  logic [31:0]       din,
  input  logic              step,
  output logic [31:0]       rd_data,
  output logic [HBM_AW-1:0] now,
  output logic              loader_mode,
  output logic              rw_mode,
  output logic              busy,
`ifdef SPMV_CFG_IRQ_EN
  output logic              irq_req,
`endif
  output logic              done
);

  ch_ctrl_t          ctrl_q;
  logic [HBM_AW-1:0] base_q, now_q;
  logic [31:0]       len_q, remain_q;
  logic              busy_q, done_q;

  logic [31:0] off_ext;
  logic wr_ctrl, wr_status, wr_base_lo, wr_base_hi, wr_now_lo, wr_now_hi, wr_len;
  logic start, step_ok, last_beat, done_clr;

  assign off_ext    = 32'(offset);
  assign wr_ctrl    = wr_en && (off_ext == OFF_CTRL);
  assign wr_status  = wr_en && (off_ext == OFF_STATUS);
  assign wr_base_lo = wr_en && (off_ext == OFF_BASE_LO);
  assign wr_base_hi = wr_en && (off_ext == OFF_BASE_HI);
  assign wr_now_lo  = wr_en && (off_ext == OFF_NOW_LO);
  assign wr_now_hi  = wr_en && (off_ext == OFF_NOW_HI);
  assign wr_len     = wr_en && (off_ext == OFF_LEN);

  assign start     = wr_ctrl && din[CTRL_START_BIT] && !busy_q;
  assign step_ok   = step && busy_q;
  assign last_beat = step_ok && (remain_q == 32'd1);
  assign done_clr  = wr_status && din[STATUS_DONE_BIT];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctrl_q   <= '0;
      base_q   <= '0;
      now_q    <= '0;
      len_q    <= '0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q.loader_mode <= din[CTRL_LOADER_BIT];
        ctrl_q.rw_mode     <= din[CTRL_RW_BIT];
`ifdef SPMV_CFG_IRQ_EN
        ctrl_q.irq_en      <= din[CTRL_IRQ_EN_BIT];
`endif
      end
      if (wr_base_lo) base_q[31:0]        <= din;
      if (wr_base_hi) base_q[HBM_AW-1:32] <= din[HBM_AW-33:0];
      if (wr_len)     len_q               <= din;

      if (start) begin
        now_q    <= base_q;
        remain_q <= len_q;
        busy_q   <= (len_q != 32'd0);
        done_q   <= (len_q == 32'd0);
      end else if (step_ok) begin
        // A step owns NOW this edge; any concurrent NOW write is dropped.
        now_q    <= now_q + HBM_AW'(STEP_BYTES);
        remain_q <= remain_q - 32'd1;
        if (last_beat) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else if (done_clr) begin
          done_q <= 1'b0;
        end
      end else begin
        if (wr_now_lo && !busy_q) now_q[31:0]        <= din;
        if (wr_now_hi && !busy_q) now_q[HBM_AW-1:32] <= din[HBM_AW-33:0];
        if (done_clr) done_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = DEAD_VALUE;
    case (off_ext)
      OFF_CTRL:    rd_data = 32'(ctrl_q);
      OFF_STATUS:  rd_data = {30'd0, done_q, busy_q};
      OFF_BASE_LO: rd_data = base_q[31:0];
      OFF_BASE_HI: rd_data = 32'(base_q[HBM_AW-1:32]);
      OFF_NOW_LO:  rd_data = now_q[31:0];
      OFF_NOW_HI:  rd_data = 32'(now_q[HBM_AW-1:32]);
      OFF_LEN:     rd_data = len_q;
      OFF_REMAIN:  rd_data = remain_q;
      default:     rd_data = DEAD_VALUE;
    endcase
  end

  assign now         = now_q;
  assign loader_mode = ctrl_q.loader_mode;
  assign rw_mode     = ctrl_q.rw_mode;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef SPMV_CFG_IRQ_EN
  assign irq_req = done_q && ctrl_q.irq_en;
  logic unused_din;
  assign unused_din = ^din[30:3];
`else
  logic unused_din;
  assign unused_din = ^din[30:2];
`endif

endmodule

// File: rtl/spmv_loader_cfg_regs.sv
// Multi-channel config/address-stepping register file for the SpMV HBM vector loaders.
// Define SPMV_CFG_IRQ_EN to add the irq output and per-channel CTRL.irq_en.
module spmv_loader_cfg_regs
  import spmv_cfg_pkg::*;
#(
  parameter int unsigned NCH            = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned HBM_AW         = 64,
  parameter int unsigned STEP_BYTES     = 64,
  parameter int unsigned CH_STRIDE_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  reg_en,
  input  logic                  reg_we,
  input  logic [ADDR_W-1:0]     reg_addr,
  input  logic [31:0]           reg_din,
  output logic [31:0]           reg_dout,
  input  logic [NCH-1:0]        ch_step,
  output logic [NCH*HBM_AW-1:0] ch_addr,
  output logic [NCH-1:0]        ch_loader_mode,
  output logic [NCH-1:0]        ch_rw_mode,
  output logic [NCH-1:0]        ch_busy,
`ifdef SPMV_CFG_IRQ_EN
  output logic                  irq,
`endif
  output logic [NCH-1:0]        ch_done
);

  localparam int unsigned IDX_W = ADDR_W - CH_STRIDE_LOG2;

  logic [IDX_W-1:0]          ch_idx;
  logic [CH_STRIDE_LOG2-1:0] offset;
  logic [NCH-1:0]            hit;
  logic [31:0]               ch_rd [NCH];
  logic [31:0]               rd_mux;
`ifdef SPMV_CFG_IRQ_EN
  logic [NCH-1:0]            irq_req;
`endif

  assign ch_idx = reg_addr[ADDR_W-1:CH_STRIDE_LOG2];
  assign offset = reg_addr[CH_STRIDE_LOG2-1:0];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign hit[i] = (ch_idx == IDX_W'(i));

    spmv_cfg_channel #(
      .HBM_AW    (HBM_AW),
      .STEP_BYTES(STEP_BYTES),
      .OFF_W     (CH_STRIDE_LOG2)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .wr_en      (reg_en && reg_we && hit[i]),
      .offset     (offset),
      .din        (reg_din),
      .step       (ch_step[i]),
      .rd_data    (ch_rd[i]),
      .now        (ch_addr[i*HBM_AW +: HBM_AW]),
      .loader_mode(ch_loader_mode[i]),
      .rw_mode    (ch_rw_mode[i]),
      .busy       (ch_busy[i]),
`ifdef SPMV_CFG_IRQ_EN
      .irq_req    (irq_req[i]),
`endif
      .done       (ch_done[i])
    );
  end

  // Out-of-range channel indices match no hit bit and fall through to DEAD_VALUE.
  always_comb begin
    rd_mux = DEAD_VALUE;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (hit[i]) rd_mux = ch_rd[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      reg_dout <= '0;
    end else if (reg_en && !reg_we) begin
      reg_dout <= rd_mux;
    end
  end

`ifdef SPMV_CFG_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rstn) irq <= 1'b0;
    else       irq <= |irq_req;
  end
`endif

endmodule

// File: tb/tb_spmv_loader_cfg_regs.sv
// Self-checking bench: directed scenarios plus random traffic against a per-channel reference model.
// Build with +define+SPMV_CFG_IRQ_EN to also cover the interrupt path.
module tb_spmv_loader_cfg_regs;

  localparam int NCH    = 4;
  localparam int HBM_AW = 64;
  localparam logic [31:0] DEAD = 32'hDEADADDE;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  reg_en, reg_we;
  logic [31:0]           reg_addr, reg_din, reg_dout;
  logic [NCH-1:0]        ch_step;
  logic [NCH*HBM_AW-1:0] ch_addr;
  logic [NCH-1:0]        ch_loader_mode, ch_rw_mode, ch_busy, ch_done;
`ifdef SPMV_CFG_IRQ_EN
  logic                  irq;
`endif

  spmv_loader_cfg_regs #(
    .NCH(NCH), .ADDR_W(32), .HBM_AW(HBM_AW), .STEP_BYTES(64), .CH_STRIDE_LOG2(5)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .reg_en        (reg_en),
    .reg_we        (reg_we),
    .reg_addr      (reg_addr),
    .reg_din       (reg_din),
    .reg_dout      (reg_dout),
    .ch_step       (ch_step),
    .ch_addr       (ch_addr),
    .ch_loader_mode(ch_loader_mode),
    .ch_rw_mode    (ch_rw_mode),
    .ch_busy       (ch_busy),
`ifdef SPMV_CFG_IRQ_EN
    .irq           (irq),
`endif
    .ch_done       (ch_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the architectural state of each channel as software sees it.
  logic [63:0] m_base [NCH];
  logic [63:0] m_now  [NCH];
  logic [31:0] m_len  [NCH];
  logic [31:0] m_rem  [NCH];
  bit          m_busy [NCH];
  bit          m_done [NCH];
  bit          m_lm   [NCH];
  bit          m_rw   [NCH];
  bit          m_ie   [NCH];
  logic [31:0] m_dout;
  bit          m_irq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    int c = int'(addr >> 5);
    int off = int'(addr & 32'h1F);
    if (c >= NCH) return DEAD;
    case (off)
      'h00: return {29'd0, m_ie[c], m_rw[c], m_lm[c]};
      'h04: return {30'd0, m_done[c], m_busy[c]};
      'h08: return m_base[c][31:0];
      'h0C: return m_base[c][63:32];
      'h10: return m_now[c][31:0];
      'h14: return m_now[c][63:32];
      'h18: return m_len[c];
      'h1C: return m_rem[c];
      default: return DEAD;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_base[c] = '0; m_now[c] = '0; m_len[c] = '0; m_rem[c] = '0;
      m_busy[c] = 0; m_done[c] = 0; m_lm[c] = 0; m_rw[c] = 0; m_ie[c] = 0;
    end
    m_dout = '0;
    m_irq  = 0;
  endtask

  task automatic model_edge(input bit en, input bit we, input logic [31:0] addr,
                            input logic [31:0] din, input logic [NCH-1:0] step);
    bit irq_n = 0;
    for (int c = 0; c < NCH; c++) irq_n |= m_done[c] & m_ie[c];
    if (en && !we) m_dout = m_read(addr);
    for (int c = 0; c < NCH; c++) begin
      bit wr    = en && we && ((addr >> 5) == 32'(c));
      int off   = int'(addr & 32'h1F);
      bit start = wr && off == 'h00 && din[31] && !m_busy[c];
      bit beat  = step[c] && m_busy[c];
      bit fin   = beat && m_rem[c] == 1;
      bit clr   = wr && off == 'h04 && din[1];
      bit nowwr = wr && !m_busy[c] && !beat;
      logic [63:0] base_old = m_base[c];
      logic [31:0] len_old  = m_len[c];
      if (wr && off == 'h00) begin
        m_lm[c] = din[0];
        m_rw[c] = din[1];
`ifdef SPMV_CFG_IRQ_EN
        m_ie[c] = din[2];
`endif
      end
      if (wr && off == 'h08) m_base[c][31:0]  = din;
      if (wr && off == 'h0C) m_base[c][63:32] = din;
      if (wr && off == 'h18) m_len[c]         = din;
      if (nowwr && off == 'h10) m_now[c][31:0]  = din;
      if (nowwr && off == 'h14) m_now[c][63:32] = din;
      if (start) begin
        m_now[c]  = base_old;
        m_rem[c]  = len_old;
        m_busy[c] = (len_old != 0);
        m_done[c] = (len_old == 0);
      end else begin
        if (beat) begin
          m_now[c] = m_now[c] + 64'd64;
          m_rem[c] = m_rem[c] - 1;
        end
        if (fin) begin
          m_busy[c] = 0;
          m_done[c] = 1;
        end else if (clr) begin
          m_done[c] = 0;
        end
      end
    end
    m_irq = irq_n;
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("ch%0d_addr", c), ch_addr[c*HBM_AW +: HBM_AW], m_now[c]);
      check($sformatf("ch%0d_busy", c), 64'(ch_busy[c]), 64'(m_busy[c]));
      check($sformatf("ch%0d_done", c), 64'(ch_done[c]), 64'(m_done[c]));
      check($sformatf("ch%0d_mode", c), {62'd0, ch_rw_mode[c], ch_loader_mode[c]},
            {62'd0, m_rw[c], m_lm[c]});
    end
    check("reg_dout", 64'(reg_dout), 64'(m_dout));
`ifdef SPMV_CFG_IRQ_EN
    check("irq", 64'(irq), 64'(m_irq));
`endif
  endtask

  task automatic tick(input bit en, input bit we, input logic [31:0] addr,
                      input logic [31:0] din, input logic [NCH-1:0] step);
    reg_en = en; reg_we = we; reg_addr = addr; reg_din = din; ch_step = step;
    @(posedge clk);
    #1;
    model_edge(en, we, addr, din, step);
    reg_en = 0; reg_we = 0; ch_step = '0;
    check_outputs();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] din);
    tick(1, 1, addr, din, '0);
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    tick(1, 0, addr, '0, '0);
    check(tag, 64'(reg_dout), 64'(exp));
  endtask

  task automatic steps(input int n, input logic [NCH-1:0] mask);
    for (int k = 0; k < n; k++) tick(0, 0, '0, '0, mask);
  endtask

  task automatic do_reset();
    rstn = 0;
    reg_en = 0; reg_we = 0; reg_addr = '0; reg_din = '0; ch_step = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    model_reset();
    check_outputs();
  endtask

  initial begin
    do_reset();

    // Reset values and out-of-range decode.
    for (int o = 0; o < 8; o++) rd_expect($sformatf("rst_ch0_off%0h", o*4), 32'(o*4), 32'd0);
    rd_expect("dead_ch_nch", 32'(NCH << 5), DEAD);
    rd_expect("dead_unaligned", 32'h0000_0002, DEAD);

    // ch1: three-beat transfer.
    wr(32'h28, 32'h0000_1000);
    wr(32'h2C, 32'h0000_0002);
    wr(32'h38, 32'd3);
    wr(32'h20, 32'h8000_0000);
    check("ch1_start_now", ch_addr[127:64], 64'h2_0000_1000);
    check("ch1_start_busy", 64'(ch_busy[1]), 64'd1);
    steps(3, 4'b0010);
    check("ch1_end_now", ch_addr[127:64], 64'h2_0000_10C0);
    check("ch1_end_busy", 64'(ch_busy[1]), 64'd0);
    check("ch1_end_done", 64'(ch_done[1]), 64'd1);
    rd_expect("ch1_remain0", 32'h3C, 32'd0);
    steps(1, 4'b0010);
    check("ch1_idle_step", ch_addr[127:64], 64'h2_0000_10C0);

    // ch0: address wraps past 2^64.
    wr(32'h08, 32'hFFFF_FFC0);
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h18, 32'd2);
    wr(32'h00, 32'h8000_0000);
    steps(2, 4'b0001);
    check("ch0_wrap_now", ch_addr[63:0], 64'h40);
    check("ch0_wrap_done", 64'(ch_done[0]), 64'd1);

    // ch3: zero-length start completes immediately, then W1C.
    wr(32'h60, 32'h8000_0000);
    check("ch3_len0_busy", 64'(ch_busy[3]), 64'd0);
    check("ch3_len0_done", 64'(ch_done[3]), 64'd1);
    wr(32'h64, 32'h2);
    check("ch3_w1c", 64'(ch_done[3]), 64'd0);

    // ch1: step beats a concurrent NOW_LO write; W1C loses to final step.
    wr(32'h20, 32'h8000_0000);
    tick(1, 1, 32'h30, 32'h1234_5678, 4'b0010);
    check("ch1_collide_now", ch_addr[127:64], 64'h2_0000_1040);
    steps(1, 4'b0010);
    tick(1, 1, 32'h24, 32'h2, 4'b0010);
    check("ch1_setwins_done", 64'(ch_done[1]), 64'd1);

    // START while busy only updates mode bits.
    wr(32'h20, 32'h8000_0000);
    wr(32'h20, 32'h8000_0003);
    rd_expect("ch1_busy_remain", 32'h3C, 32'd3);
    rd_expect("ch1_busy_ctrl", 32'h20, 32'h3);

    // CTRL bit2 storage depends on the irq build.
    wr(32'h40, 32'h7);
`ifdef SPMV_CFG_IRQ_EN
    rd_expect("ch2_ctrl_ie", 32'h40, 32'h7);
    wr(32'h58, 32'd1);
    wr(32'h40, 32'h8000_0004);
    steps(1, 4'b0100);
    check("irq_lag", 64'(irq), 64'd0);
    steps(1, 4'b0000);
    check("irq_rise", 64'(irq), 64'd1);
    wr(32'h44, 32'h2);
    check("irq_still", 64'(irq), 64'd1);
    steps(1, 4'b0000);
    check("irq_fall", 64'(irq), 64'd0);
`else
    rd_expect("ch2_ctrl_noie", 32'h40, 32'h3);
`endif

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bit          en   = ($urandom_range(0, 3) != 0);
      bit          we   = $urandom_range(0, 1);
      int          c    = $urandom_range(0, NCH);
      int          off  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 31)
                                                      : $urandom_range(0, 7) * 4;
      logic [31:0] din  = $urandom;
      logic [NCH-1:0] st = 4'($urandom);
      if (off == 'h18) din = 32'($urandom_range(0, 6));
      if (off == 'h00) din[31] = ($urandom_range(0, 2) == 0);
      tick(en, we, 32'(c << 5) | 32'(off), din, st);
    end

    // Reset mid-transfer.
    wr(32'h38, 32'd5);
    wr(32'h20, 32'h8000_0001);
    steps(1, 4'b0010);
    do_reset();
    check("rst_mid_busy", 64'(ch_busy), 64'd0);
    check("rst_mid_addr1", ch_addr[127:64], 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
